period_stable_detect: RTL

Upstream conditioning stage for the ADC capture double buffer. Takes the asynchronous comparator square wave, measures its period in system-clock cycles, and asserts `stable` once the period has held within tolerance for a set number of consecutive cycles. The capture buffer consumes `stable` and `signal_sync`, so capture only starts on a locked, periodic input.

---
 rtl/meas_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 29 ++
 rtl/period_stable_detect.sv | 135 +++++++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// Shared types and default parameters for the period measurement and lock detector.
package meas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } pstab_state_t;

    localparam int DEF_CNT_WIDTH    = 24;
    localparam int DEF_TOL_SHIFT    = 4;
    localparam int DEF_STABLE_COUNT = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-FF synchronizer for an asynchronous level plus a rising-edge detect register.
// Also used for adc_clk edge detection, so the chain depth is a parameter.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign sync = r_sync[STAGES-1];
    assign rise = r_sync[STAGES-1] & ~r_last;

endmodule

// File: rtl/period_stable_detect.sv
// Measures the period of a synchronized square wave between rising edges and
// asserts stable once enough consecutive periods agree within tolerance.
module period_stable_detect
    import meas_pkg::*;
#(
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int TOL_SHIFT    = DEF_TOL_SHIFT,
    parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 signal_in,
    output logic                 signal_sync,
    output logic                 stable,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 timeout,
    output pstab_state_t         dbg_state
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_COUNT);

    pstab_state_t         r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic [CNT_WIDTH-1:0] r_prev, w_prev_next;
    logic [CNT_WIDTH-1:0] r_period, w_period_next;
    logic [3:0]           r_match_cnt, w_match_next;
    logic                 r_period_valid, w_pv_next;
    logic                 r_timeout, w_to_next;
    logic                 r_stable, w_stable_next;

    logic                 w_sync, w_rise;
    logic [CNT_WIDTH-1:0] w_new, w_tol;
    logic [CNT_WIDTH:0]   w_diff;
    logic                 w_match, w_sat;

    sync_edge_det #(.STAGES(2)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (signal_in),
        .sync     (w_sync),
        .rise     (w_rise)
    );

    assign w_new   = r_cnt + 1'b1;
    assign w_tol   = r_prev >> TOL_SHIFT;
    assign w_diff  = (w_new >= r_prev) ? {1'b0, w_new - r_prev} : {1'b0, r_prev - w_new};
    assign w_match = (w_diff <= {1'b0, w_tol});
    assign w_sat   = &r_cnt;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_prev_next   = r_prev;
        w_period_next = r_period;
        w_match_next  = r_match_cnt;
        w_pv_next     = 1'b0;
        w_to_next     = 1'b0;

        if (!en) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_match_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_next   = '0;
                    w_match_next = '0;
                    if (w_rise) w_state_next = FIRST;
                end
                FIRST, TRACK: begin
                    w_cnt_next = r_cnt + 1'b1;
                    // A rise on the saturated count still yields a measurement.
                    if (w_rise) begin
                        if (r_state == TRACK) begin
                            if (w_match)
                                w_match_next = (r_match_cnt >= STABLE_LIM) ? STABLE_LIM
                                                                           : r_match_cnt + 4'd1;
                            else
                                w_match_next = '0;
                        end
                        w_prev_next   = w_new;
                        w_period_next = w_new;
                        w_pv_next     = 1'b1;
                        w_cnt_next    = '0;
                        w_state_next  = TRACK;
                    end else if (w_sat) begin
                        w_to_next    = 1'b1;
                        w_match_next = '0;
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_match_next = '0;
                end
            endcase
        end

        w_stable_next = (w_match_next == STABLE_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_prev         <= '0;
            r_period       <= '0;
            r_match_cnt    <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_stable       <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_prev         <= w_prev_next;
            r_period       <= w_period_next;
            r_match_cnt    <= w_match_next;
            r_period_valid <= w_pv_next;
            r_timeout      <= w_to_next;
            r_stable       <= w_stable_next;
        end
    end

    assign signal_sync  = w_sync;
    assign stable       = r_stable;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;
    assign dbg_state    = r_state;

endmodule
